// File: rtl/yutorina_exc_ctrl_pkg.sv
// Shared bus widths, SPR map, exception/control-op codes and cause layout for
// the exception controller and its interrupt priority encoder.
package yutorina_exc_ctrl_pkg;

    localparam int WORD_DATA_W = 32;
    localparam int WORD_ADDR_W = 30;
    localparam int SPR_ADDR_W  = 5;
    localparam int EXP_W       = 3;
    localparam int CTRL_OP_W   = 2;
    localparam int INT_IDX_W   = 8;
    localparam int CAUSE_W     = EXP_W + 1 + INT_IDX_W;

    typedef logic [WORD_DATA_W-1:0] word_data_t;
    typedef logic [WORD_ADDR_W-1:0] word_addr_t;
    typedef logic [SPR_ADDR_W-1:0]  spr_addr_t;
    typedef logic [EXP_W-1:0]       exp_code_t;
    typedef logic [CTRL_OP_W-1:0]   ctrl_op_t;
    typedef logic [CAUSE_W-1:0]     cause_t;

    localparam ctrl_op_t CTRL_NOP  = 2'd0;
    localparam ctrl_op_t CTRL_WRCR = 2'd1;
    localparam ctrl_op_t CTRL_ERET = 2'd2;

    localparam exp_code_t EXP_NONE       = 3'd0;
    localparam exp_code_t EXP_INT        = 3'd1;
    localparam exp_code_t EXP_UNDEF_INSN = 3'd2;
    localparam exp_code_t EXP_OVERFLOW   = 3'd3;
    localparam exp_code_t EXP_MISS_ALIGN = 3'd4;
    localparam exp_code_t EXP_TRAP       = 3'd5;
    localparam exp_code_t EXP_PRV_VIO    = 3'd6;

    localparam spr_addr_t SPR_MODE   = 5'd0;
    localparam spr_addr_t SPR_PC     = 5'd1;
    localparam spr_addr_t SPR_EPC    = 5'd2;
    localparam spr_addr_t SPR_VECTOR = 5'd3;
    localparam spr_addr_t SPR_CNT_L  = 5'd4;
    localparam spr_addr_t SPR_CNT_H  = 5'd5;
    localparam spr_addr_t SPR_CAUSE  = 5'd6;
    localparam spr_addr_t SPR_IMASK  = 5'd7;
    localparam spr_addr_t SPR_IPEND  = 5'd8;
    localparam spr_addr_t SPR_CMP    = 5'd9;

    localparam logic MODE_KERNEL = 1'b0;
    localparam logic MODE_USER   = 1'b1;

    // Cause layout: [11:9] exception code, [8] interrupt flag, [7:0] line index.
    localparam int CAUSE_IDX_LSB = 0;
    localparam int CAUSE_INT_BIT = INT_IDX_W;
    localparam int CAUSE_EXP_LSB = INT_IDX_W + 1;

    function automatic cause_t make_cause(input exp_code_t code, input logic is_int,
                                          input logic [INT_IDX_W-1:0] idx);
        return {code, is_int, idx};
    endfunction

endpackage

// File: rtl/yutorina_int_prio.sv
// Lowest-index-first priority encoder over the enabled interrupt vector
// (external lines plus the timer line at the top).
module yutorina_int_prio
    import yutorina_exc_ctrl_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N-1:0]         req,
    output logic                 valid,
    output logic [INT_IDX_W-1:0] idx
);

    // Scanning downward lets the lowest set index overwrite any higher one.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = INT_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/yutorina_exc_ctrl.sv
// CPU control unit: stall/flush/redirect generation, exception entry and ERET,
// SPR file, external interrupt controller and cycle-counter timer compare.
module yutorina_exc_ctrl
    import yutorina_exc_ctrl_pkg::*;
#(
    parameter int INT_NUM = 8,
    parameter int CNT_W   = 64,
    parameter int SYNC_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_busy,
    input  logic               d_busy,
    input  ctrl_op_t           ctrl_op,
    input  logic               id_en_,
    input  logic               mem_en_,
    input  exp_code_t          exp_code,
    input  logic [INT_NUM-1:0] irq,
    input  logic               we_,
    input  word_addr_t         mem_pc,
    input  spr_addr_t          r_addr,
    input  spr_addr_t          w_addr,
    input  word_data_t         w_data,
    output word_data_t         r_data,
    output logic               mode,
    output logic               stall,
    output logic               flush,
    output logic               id_flush,
    output word_addr_t         new_pc,
    output logic               int_req
);

    logic               flush_q, flush_d;
    logic               id_flush_q, id_flush_d;
    word_addr_t         new_pc_q, new_pc_d;
    word_addr_t         epc_q, epc_d;
    word_addr_t         v_addr_q, v_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               pre_mode_q, pre_mode_d;
    logic               int_mask_q, int_mask_d;
    logic [INT_NUM:0]   imask_q, imask_d;
    logic               tmr_pend_q, tmr_pend_d;
    cause_t             cause_q, cause_d;
    word_data_t         cmp_q, cmp_d;
    logic               cmp_en_q, cmp_en_d;

    logic [INT_NUM-1:0]   irq_lvl;
    logic [INT_NUM:0]     pend;
    logic [INT_NUM:0]     en;
    logic                 en_any;
    logic [INT_IDX_W-1:0] en_idx;
    logic                 tmr_hit;
    logic                 is_eret;
    logic                 take_exc;

    generate
        if (SYNC_EN != 0) begin : g_sync
            logic [INT_NUM-1:0] meta_q, sync_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    meta_q <= '0;
                    sync_q <= '0;
                end else begin
                    meta_q <= irq;
                    sync_q <= meta_q;
                end
            end
            assign irq_lvl = sync_q;
        end else begin : g_direct
            assign irq_lvl = irq;
        end
    endgenerate

    // External lines are level mirrors; only the timer bit is sticky.
    assign pend    = {tmr_pend_q, irq_lvl};
    assign en      = pend & imask_q;
    assign tmr_hit = cmp_en_q && (cnt_q[31:0] == cmp_q);

    yutorina_int_prio #(.N(INT_NUM + 1)) u_prio (
        .req   (en),
        .valid (en_any),
        .idx   (en_idx)
    );

    assign stall    = i_busy | d_busy;
    assign int_req  = en_any & ~int_mask_q;
    assign mode     = mode_q;
    assign flush    = flush_q;
    assign id_flush = id_flush_q;
    assign new_pc   = new_pc_q;

    assign is_eret  = !id_en_ && (ctrl_op == CTRL_ERET);
    // A masked or empty interrupt request is not an exception at all.
    assign take_exc = !mem_en_ && !flush_q && (exp_code != EXP_NONE) &&
                      !((exp_code == EXP_INT) && (int_mask_q || !en_any));

    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        tmr_pend_d = tmr_pend_q | tmr_hit;
        flush_d    = flush_q;
        id_flush_d = id_flush_q;
        new_pc_d   = new_pc_q;
        epc_d      = epc_q;
        v_addr_d   = v_addr_q;
        mode_d     = mode_q;
        pre_mode_d = pre_mode_q;
        int_mask_d = int_mask_q;
        imask_d    = imask_q;
        cause_d    = cause_q;
        cmp_d      = cmp_q;
        cmp_en_d   = cmp_en_q;

        if (!stall) begin
            if (is_eret) begin
                flush_d    = 1'b1;
                id_flush_d = 1'b1;
                new_pc_d   = epc_q;
                epc_d      = '0;
                mode_d     = pre_mode_q;
                pre_mode_d = MODE_KERNEL;
                int_mask_d = 1'b0;
            end else if (take_exc) begin
                flush_d    = 1'b1;
                id_flush_d = 1'b0;
                new_pc_d   = v_addr_q;
                epc_d      = mem_pc;
                pre_mode_d = mode_q;
                mode_d     = MODE_KERNEL;
                int_mask_d = 1'b1;
                cause_d    = make_cause(exp_code, exp_code == EXP_INT, en_idx);
            end else if (!mem_en_ && !we_) begin
                flush_d    = 1'b1;
                id_flush_d = 1'b0;
                new_pc_d   = mem_pc;
                case (w_addr)
                    SPR_VECTOR: v_addr_d = w_data[WORD_DATA_W-1:2];
                    SPR_MODE:   mode_d   = w_data[0];
                    SPR_IMASK:  imask_d  = w_data[INT_NUM:0];
                    SPR_IPEND: begin
                        if (w_data[INT_NUM]) begin
                            tmr_pend_d = 1'b0;
                        end
                    end
                    // Rearming the compare discards a coincident match.
                    SPR_CMP: begin
                        cmp_d      = w_data;
                        cmp_en_d   = 1'b1;
                        tmr_pend_d = 1'b0;
                    end
                    default: ;
                endcase
            end else if (!mem_en_) begin
                flush_d    = 1'b0;
                id_flush_d = 1'b0;
                new_pc_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_q    <= 1'b0;
            id_flush_q <= 1'b0;
            new_pc_q   <= '0;
            epc_q      <= '0;
            v_addr_q   <= '0;
            cnt_q      <= '0;
            mode_q     <= MODE_KERNEL;
            pre_mode_q <= MODE_KERNEL;
            int_mask_q <= 1'b1;
            imask_q    <= '0;
            tmr_pend_q <= 1'b0;
            cause_q    <= '0;
            cmp_q      <= '0;
            cmp_en_q   <= 1'b0;
        end else begin
            flush_q    <= flush_d;
            id_flush_q <= id_flush_d;
            new_pc_q   <= new_pc_d;
            epc_q      <= epc_d;
            v_addr_q   <= v_addr_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            pre_mode_q <= pre_mode_d;
            int_mask_q <= int_mask_d;
            imask_q    <= imask_d;
            tmr_pend_q <= tmr_pend_d;
            cause_q    <= cause_d;
            cmp_q      <= cmp_d;
            cmp_en_q   <= cmp_en_d;
        end
    end

    always_comb begin
        r_data = '0;
        case (r_addr)
            SPR_MODE:   r_data = WORD_DATA_W'(mode_q);
            SPR_PC:     r_data = {mem_pc, 2'b00};
            SPR_EPC:    r_data = {epc_q, 2'b00};
            SPR_VECTOR: r_data = {v_addr_q, 2'b00};
            SPR_CNT_L:  r_data = cnt_q[31:0];
            SPR_CNT_H:  r_data = WORD_DATA_W'(cnt_q[CNT_W-1:32]);
            SPR_CAUSE:  r_data = WORD_DATA_W'(cause_q);
            SPR_IMASK:  r_data = WORD_DATA_W'(imask_q);
            SPR_IPEND:  r_data = WORD_DATA_W'(pend);
            SPR_CMP:    r_data = cmp_q;
            default:    r_data = '0;
        endcase
    end

endmodule

// File: tb/tb_yutorina_exc_ctrl.sv
// Bench for yutorina_exc_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the control unit.
module tb_yutorina_exc_ctrl;
    import yutorina_exc_ctrl_pkg::*;

    localparam int INT_NUM = 8;

    logic               clk;
    logic               rst;
    logic               i_busy, d_busy;
    ctrl_op_t           ctrl_op;
    logic               id_en_, mem_en_;
    exp_code_t          exp_code;
    logic [INT_NUM-1:0] irq;
    logic               we_;
    word_addr_t         mem_pc;
    spr_addr_t          r_addr, w_addr;
    word_data_t         w_data, r_data;
    logic               mode, stall, flush, id_flush, int_req;
    word_addr_t         new_pc;

    int n_tests = 0;
    int n_fail  = 0;

    yutorina_exc_ctrl #(.INT_NUM(INT_NUM), .CNT_W(64), .SYNC_EN(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_busy   (i_busy),
        .d_busy   (d_busy),
        .ctrl_op  (ctrl_op),
        .id_en_   (id_en_),
        .mem_en_  (mem_en_),
        .exp_code (exp_code),
        .irq      (irq),
        .we_      (we_),
        .mem_pc   (mem_pc),
        .r_addr   (r_addr),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .r_data   (r_data),
        .mode     (mode),
        .stall    (stall),
        .flush    (flush),
        .id_flush (id_flush),
        .new_pc   (new_pc),
        .int_req  (int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [63:0]        m_cnt;
    logic [INT_NUM-1:0] irq_hist[$];
    logic               m_tmr;
    logic [31:0]        m_cmp;
    logic               m_cmp_en;
    logic [INT_NUM:0]   m_imask;
    logic               m_mode, m_pre_mode, m_int_mask;
    logic [29:0]        m_epc, m_vaddr, m_new_pc;
    logic               m_flush, m_id_flush;
    logic [11:0]        m_cause;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [INT_NUM:0] m_pend();
        return {m_tmr, irq_hist[0]};
    endfunction

    function automatic logic [7:0] lowest(input logic [INT_NUM:0] v);
        for (int i = 0; i <= INT_NUM; i++) begin
            if (v[i]) return 8'(i);
        end
        return 8'd0;
    endfunction

    function automatic logic [31:0] model_read(input spr_addr_t a);
        case (a)
            SPR_MODE:   return {31'b0, m_mode};
            SPR_PC:     return {mem_pc, 2'b00};
            SPR_EPC:    return {m_epc, 2'b00};
            SPR_VECTOR: return {m_vaddr, 2'b00};
            SPR_CNT_L:  return m_cnt[31:0];
            SPR_CNT_H:  return m_cnt[63:32];
            SPR_CAUSE:  return {20'b0, m_cause};
            SPR_IMASK:  return {23'b0, m_imask};
            SPR_IPEND:  return {23'b0, m_pend()};
            SPR_CMP:    return m_cmp;
            default:    return 32'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = '0; m_tmr = 1'b0; m_cmp = '0; m_cmp_en = 1'b0; m_imask = '0;
        m_mode = MODE_KERNEL; m_pre_mode = MODE_KERNEL; m_int_mask = 1'b1;
        m_epc = '0; m_vaddr = '0; m_new_pc = '0; m_flush = 1'b0; m_id_flush = 1'b0;
        m_cause = '0;
        irq_hist.delete();
        irq_hist.push_back('0);
        irq_hist.push_back('0);
    endtask

    // One rising edge with the inputs currently applied.
    task automatic model_step();
        logic [INT_NUM:0] en;
        logic             hit, take_exc;
        en  = m_pend() & m_imask;
        hit = m_cmp_en && (m_cnt[31:0] == m_cmp);
        irq_hist.push_back(irq);
        void'(irq_hist.pop_front());
        m_cnt = m_cnt + 64'd1;
        m_tmr = m_tmr | hit;
        if (!(i_busy || d_busy)) begin
            take_exc = !mem_en_ && !m_flush && exp_code != EXP_NONE &&
                       !(exp_code == EXP_INT && (m_int_mask || en == 0));
            if (!id_en_ && ctrl_op == CTRL_ERET) begin
                m_flush = 1'b1; m_id_flush = 1'b1; m_new_pc = m_epc; m_epc = '0;
                m_mode = m_pre_mode; m_pre_mode = MODE_KERNEL; m_int_mask = 1'b0;
            end else if (take_exc) begin
                m_flush = 1'b1; m_id_flush = 1'b0; m_new_pc = m_vaddr; m_epc = mem_pc;
                m_pre_mode = m_mode; m_mode = MODE_KERNEL; m_int_mask = 1'b1;
                m_cause = {exp_code, exp_code == EXP_INT, lowest(en)};
            end else if (!mem_en_ && !we_) begin
                m_flush = 1'b1; m_id_flush = 1'b0; m_new_pc = mem_pc;
                case (w_addr)
                    SPR_VECTOR: m_vaddr = w_data[31:2];
                    SPR_MODE:   m_mode = w_data[0];
                    SPR_IMASK:  m_imask = w_data[INT_NUM:0];
                    SPR_IPEND:  if (w_data[INT_NUM]) m_tmr = 1'b0;
                    SPR_CMP: begin m_cmp = w_data; m_cmp_en = 1'b1; m_tmr = 1'b0; end
                    default: ;
                endcase
            end else if (!mem_en_) begin
                m_flush = 1'b0; m_id_flush = 1'b0; m_new_pc = '0;
            end
        end
    endtask

    task automatic check_all();
        chk("flush", 32'(flush), 32'(m_flush));
        chk("id_flush", 32'(id_flush), 32'(m_id_flush));
        chk("new_pc", 32'(new_pc), 32'(m_new_pc));
        chk("mode", 32'(mode), 32'(m_mode));
        chk("stall", 32'(stall), 32'(i_busy | d_busy));
        chk("int_req", 32'(int_req), 32'(((m_pend() & m_imask) != 0) && !m_int_mask));
        chk("r_data", r_data, model_read(r_addr));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_step();
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        i_busy = 1'b0; d_busy = 1'b0; id_en_ = 1'b1; ctrl_op = CTRL_NOP;
        mem_en_ = 1'b0; we_ = 1'b1; exp_code = EXP_NONE;
    endtask

    task automatic spr_write(input spr_addr_t a, input word_data_t d);
        idle_inputs();
        we_ = 1'b0; w_addr = a; w_data = d;
        step();
        idle_inputs();
    endtask

    logic [31:0] c0;

    initial begin
        rst = 1'b0;
        idle_inputs();
        irq = '0; r_addr = SPR_MODE; w_addr = '0; w_data = '0; mem_pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_int_req", 32'(int_req), 32'd0);
        for (int a = 0; a < 12; a++) begin
            r_addr = 5'(a);
            #1;
            check_all();
        end
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Interrupt entry through ERET-unmasked line 1
        mem_pc = 30'h100;
        spr_write(SPR_VECTOR, 32'h0000_4000);
        spr_write(SPR_IMASK, 32'h3);
        step();
        id_en_ = 1'b0; ctrl_op = CTRL_ERET;
        step();
        chk("eret_id_flush", 32'(id_flush), 32'd1);
        idle_inputs();
        irq = 8'h06;
        step();
        chk("irq_lat1", 32'(int_req), 32'd0);
        step();
        chk("irq_lat2", 32'(int_req), 32'd1);
        exp_code = EXP_INT; r_addr = SPR_EPC;
        step();
        chk("int_flush", 32'(flush), 32'd1);
        chk("int_new_pc", 32'(new_pc), 32'h1000);
        chk("int_epc", r_data, 32'h400);
        chk("int_mode", 32'(mode), 32'(MODE_KERNEL));
        idle_inputs(); r_addr = SPR_CAUSE;
        step();
        chk("int_cause", r_data, 32'h301);

        // EXP_INT while int_mask=1, then a non-INT exception shadowed by flush
        r_addr = SPR_EPC; mem_pc = 30'h200; exp_code = EXP_INT;
        step();
        chk("masked_int_flush", 32'(flush), 32'd0);
        chk("masked_int_epc", r_data, 32'h400);
        spr_write(5'd20, 32'h0);
        exp_code = EXP_TRAP; mem_pc = 30'h300;
        step();
        chk("shadow_exc_flush", 32'(flush), 32'd0);
        chk("shadow_exc_epc", r_data, 32'h400);

        // ERET in ID beats a simultaneous MEM exception
        spr_write(SPR_MODE, 32'h1);
        step();
        id_en_ = 1'b0; ctrl_op = CTRL_ERET; exp_code = EXP_TRAP; mem_pc = 30'h77;
        step();
        chk("eret_win_new_pc", 32'(new_pc), 32'h100);
        chk("eret_win_id_flush", 32'(id_flush), 32'd1);
        chk("eret_win_epc", r_data, 32'h0);
        idle_inputs();

        // EXP_INT with nothing enabled pending
        irq = '0;
        repeat (2) step();
        exp_code = EXP_INT; mem_pc = 30'h88;
        step();
        chk("empty_int_flush", 32'(flush), 32'd0);
        chk("empty_int_epc", r_data, 32'h0);
        idle_inputs();

        // Timer compare, sticky pend, write-1-clear
        spr_write(SPR_IMASK, 32'h103);
        spr_write(SPR_CMP, m_cnt[31:0] + 32'd20);
        r_addr = SPR_IPEND;
        repeat (25) step();
        chk("tmr_pend_set", 32'(r_data[INT_NUM]), 32'd1);
        repeat (3) step();
        chk("tmr_pend_held", 32'(r_data[INT_NUM]), 32'd1);
        chk("tmr_int_req", 32'(int_req), 32'd1);
        spr_write(SPR_IPEND, 32'h100);
        chk("tmr_pend_clr", 32'(r_data[INT_NUM]), 32'd0);

        // Stall during an SPR write
        r_addr = SPR_VECTOR; c0 = m_cnt[31:0];
        i_busy = 1'b1; we_ = 1'b0; w_addr = SPR_VECTOR; w_data = 32'h8000;
        repeat (5) begin
            step();
            chk("stall_flush", 32'(flush), 32'd1);
            chk("stall_vaddr", r_data, 32'h4000);
        end
        r_addr = SPR_CNT_L;
        #1;
        chk("stall_cnt", r_data, c0 + 32'd5);
        i_busy = 1'b0; r_addr = SPR_VECTOR;
        step();
        chk("unstall_vaddr", r_data, 32'h8000);
        idle_inputs();

        // Asynchronous reset with a redirect outstanding
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_mid_flush", 32'(flush), 32'd0);
        chk("rst_mid_new_pc", 32'(new_pc), 32'd0);
        chk("rst_mid_int_req", 32'(int_req), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            i_busy   = ($urandom_range(0, 9) == 0);
            d_busy   = ($urandom_range(0, 9) == 0);
            id_en_   = ($urandom_range(0, 3) != 0);
            ctrl_op  = 2'($urandom_range(0, 3));
            mem_en_  = ($urandom_range(0, 4) == 0);
            exp_code = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 6)) : EXP_NONE;
            we_      = ($urandom_range(0, 1) == 0);
            w_addr   = 5'($urandom_range(0, 11));
            w_data   = $urandom;
            if (w_addr == SPR_CMP) w_data = m_cnt[31:0] + 32'($urandom_range(2, 30));
            if ($urandom_range(0, 7) == 0) irq = 8'($urandom);
            mem_pc   = 30'($urandom);
            r_addr   = 5'($urandom_range(0, 15));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
